fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Two-wide instruction queue between the instruction ROM (two 32-bit words per cycle) and the decode stage.
- Each accepted ROM pair is tagged with its PC. The block presents up to two oldest instructions to decode in show-ahead form, and decode retires 0, 1 or 2 per cycle.
- Absorbs decode stalls and partial issue, and is flushed on a control-flow redirect.

Parameters:
- DEPTH, 8, entry count (instructions); power of two, >= 4.
- XLEN, 32, instruction and PC width.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_flush  in  1  redirect; discard all queued entries.
- i_valid  in  1  ROM pair valid this cycle.
- i_pc  in  XLEN  PC of i_instA; bits [1:0] ignored (treated as 0).
- i_instA  in  XLEN  older ROM word, at i_pc.
- i_instB  in  XLEN  younger ROM word, at i_pc+4.
- o_ready  out  1  buffer can accept a full pair this cycle.
- i_deq_cnt  in  2  number of head entries decode consumes (0, 1, 2; 3 treated as 2).
- o_validA  out  1  head entry valid.
- o_validB  out  1  head+1 entry valid.
- o_instA  out  XLEN  head instruction.
- o_pcA  out  XLEN  head PC.
- o_instB  out  XLEN  head+1 instruction.
- o_pcB  out  XLEN  head+1 PC.
- o_count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async assert, sync-safe release):
  - wr_ptr, rd_ptr and count clear to 0.
  - o_validA, o_validB and o_count are 0; o_ready is 1.
  - All instruction/PC outputs are 0.
  - Storage array is not reset.
- Storage: DEPTH entries of {pc, inst}. wr_ptr and rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- o_ready = (count <= DEPTH-2), from registered state only; no combinational path from i_deq_cnt.
- Enqueue occurs when i_valid && o_ready && !i_flush:
  - entry[wr_ptr] <= {i_pc&~3, i_instA}.
  - entry[wr_ptr+1] <= {(i_pc&~3)+4, i_instB}; the +4 wraps modulo 2^XLEN.
  - wr_ptr += 2.
  - If i_valid && !o_ready, the pair is dropped; upstream must hold it.
- Effective dequeue: eff_deq = min(i_deq_cnt clamped to 2, count). Over-request is silently clamped and never underflows. rd_ptr += eff_deq.
- Next count = count + 2*enq - eff_deq, where enq is the enqueue condition.
- Simultaneous enqueue and dequeue at count = DEPTH-2 is legal and yields count = DEPTH - eff_deq.
- Read side is show-ahead, combinational from current state:
  - o_validA = (count >= 1); o_validB = (count >= 2).
  - o_instA/o_pcA = entry[rd_ptr]; o_instB/o_pcB = entry[rd_ptr+1 mod DEPTH].
  - Any output whose valid is 0 is driven to 0.
- Flush has priority over enqueue and dequeue:
  - Next cycle: rd_ptr = wr_ptr = count = 0 and outputs invalid.
  - A pair presented in the same cycle as flush is not written.
  - Enqueue resumes the cycle after flush.
- Wrap-around: entries straddling index DEPTH-1 to 0 are read and written correctly. Because DEPTH is a power of two, pairs never split unevenly, but a single dequeue makes rd_ptr odd and that case must work.
- Reset asserted mid-operation empties the queue immediately, independent of the clock.

Test Plan:
- Reset, then enqueue one pair i_pc=0x100, instA=0x00500093, instB=0x00A00113 with i_deq_cnt=0 -> next cycle count=2, o_validA=o_validB=1, o_pcA=0x100, o_pcB=0x104, instructions match.
- Enqueue 4 pairs with i_deq_cnt=0 (DEPTH=8) -> count reaches 8, o_ready=0 at count 7/8; a 5th i_valid pair is dropped; then dequeue 1/cycle -> PCs emerge in strict order 0x100..0x11C.
- Steady state, count=6: enqueue plus i_deq_cnt=2 each cycle for 10 cycles -> count stays 6 across pointer wrap; one dequeue of 1 followed by pairs exercises odd rd_ptr wrap with correct PC ordering.
- count=1, i_deq_cnt=2 -> eff_deq=1, next count=0, o_validA=0 and outputs 0; i_deq_cnt=3 on empty -> no change.
- count=5 with i_valid=1 and i_flush=1 in the same cycle -> next cycle count=0, outputs invalid, flushed pair absent; the next pair at i_pc=0x200 appears at head.
- Assert i_rst_n=0 between clock edges with count=4 -> o_validA/o_validB/o_count drop to 0 immediately and o_ready=1.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: ROM-side pair write, decode-side show-ahead read.
// master drives the ROM/decode inputs, slave is the buffer itself.
interface fetch_buffer_if #(
  parameter int XLEN = 32,
  parameter int CW   = 4
);
  logic            i_flush;
  logic            i_valid;
  logic [XLEN-1:0] i_pc;
  logic [XLEN-1:0] i_instA;
  logic [XLEN-1:0] i_instB;
  logic            o_ready;
  logic [1:0]      i_deq_cnt;
  logic            o_validA;
  logic            o_validB;
  logic [XLEN-1:0] o_instA;
  logic [XLEN-1:0] o_pcA;
  logic [XLEN-1:0] o_instB;
  logic [XLEN-1:0] o_pcB;
  logic [CW-1:0]   o_count;

  modport master (
    output i_flush,
    output i_valid,
    output i_pc,
    output i_instA,
    output i_instB,
    output i_deq_cnt,
    input  o_ready,
    input  o_validA,
    input  o_validB,
    input  o_instA,
    input  o_pcA,
    input  o_instB,
    input  o_pcB,
    input  o_count
  );

  modport slave (
    input  i_flush,
    input  i_valid,
    input  i_pc,
    input  i_instA,
    input  i_instB,
    input  i_deq_cnt,
    output o_ready,
    output o_validA,
    output o_validB,
    output o_instA,
    output o_pcA,
    output o_instB,
    output o_pcB,
    output o_count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Two-wide PC-tagged instruction queue between ROM and decode.
// Show-ahead read of the two oldest entries; flush on redirect.
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  fetch_buffer_if.slave fb
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] wr_ptr_d;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [AW-1:0] wr_nxt;
  logic [AW-1:0] rd_nxt;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] req;
  logic [CW-1:0] eff_deq;
  logic          ready;
  logic          enq;
  logic          val_a;
  logic          val_b;
  logic [XLEN-1:0] pc_a;
  logic [XLEN-1:0] pc_b;
  entry_t        head_a;
  entry_t        head_b;

  assign ready  = count_q <= CW'(DEPTH - 2);
  assign enq    = fb.i_valid & ready & ~fb.i_flush;
  assign pc_a   = fb.i_pc & ~XLEN'(3);
  assign pc_b   = pc_a + XLEN'(4);
  assign wr_nxt = wr_ptr_q + AW'(1);
  assign rd_nxt = rd_ptr_q + AW'(1);

  always_comb begin
    req = '0;
    unique case (fb.i_deq_cnt)
      2'd0:    req = CW'(0);
      2'd1:    req = CW'(1);
      default: req = CW'(2);
    endcase
  end

  // Over-request clamps to occupancy so the queue never underflows.
  assign eff_deq = (req > count_q) ? count_q : req;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (fb.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + eff_deq[AW-1:0];
      if (enq) begin
        wr_ptr_d = wr_ptr_q + AW'(2);
      end
      count_d = count_q
              + (enq ? CW'(2) : CW'(0))
              - eff_deq;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      mem_q[wr_ptr_q] <= '{pc: pc_a, inst: fb.i_instA};
      mem_q[wr_nxt]   <= '{pc: pc_b, inst: fb.i_instB};
    end
  end

  assign val_a  = count_q != '0;
  assign val_b  = count_q >= CW'(2);
  assign head_a = val_a ? mem_q[rd_ptr_q] : '0;
  assign head_b = val_b ? mem_q[rd_nxt] : '0;

  assign fb.o_ready  = ready;
  assign fb.o_count  = count_q;
  assign fb.o_validA = val_a;
  assign fb.o_validB = val_b;
  assign fb.o_instA  = head_a.inst;
  assign fb.o_pcA    = head_a.pc;
  assign fb.o_instB  = head_b.inst;
  assign fb.o_pcB    = head_b.pc;
endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: vector table with expected occupancy,
// queue scoreboard for head contents, plus an async reset sequence.
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int CW    = 4;

  logic clk;
  logic rst_n;

  fetch_buffer_if #(.XLEN(XLEN), .CW(CW)) bus ();

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .fb      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  dq;
    logic        fl;
    int          exp;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[$];
  int   n_chk;
  int   n_fail;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_sb();
    int sz;
    sz = sb.size();
    chk("count", 64'(bus.o_count), 64'(sz));
    chk("ready", 64'(bus.o_ready), 64'(sz <= DEPTH - 2));
    chk("validA", 64'(bus.o_validA), 64'(sz >= 1));
    chk("validB", 64'(bus.o_validB), 64'(sz >= 2));
    chk("pcA", 64'(bus.o_pcA), 64'(sz >= 1 ? sb[0].pc : 0));
    chk("instA", 64'(bus.o_instA), 64'(sz >= 1 ? sb[0].inst : 0));
    chk("pcB", 64'(bus.o_pcB), 64'(sz >= 2 ? sb[1].pc : 0));
    chk("instB", 64'(bus.o_instB), 64'(sz >= 2 ? sb[1].inst : 0));
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] dq, input logic fl);
    int n;
    bit rdy;
    logic [31:0] base;
    bus.i_valid   = v;
    bus.i_pc      = pc;
    bus.i_instA   = a;
    bus.i_instB   = b;
    bus.i_deq_cnt = dq;
    bus.i_flush   = fl;
    rdy = sb.size() <= DEPTH - 2;
    if (fl) begin
      sb.delete();
    end else begin
      n = (dq == 2'd3) ? 2 : int'(dq);
      for (int i = 0; i < n; i++)
        if (sb.size() > 0) void'(sb.pop_front());
      if (v && rdy) begin
        base = pc & ~32'h3;
        sb.push_back('{pc: base, inst: a});
        sb.push_back('{pc: base + 32'd4, inst: b});
      end
    end
  endtask

  function automatic void add(input logic v, input logic [31:0] pc,
                              input logic [1:0] dq, input logic fl,
                              input int exp);
    vecs.push_back('{v: v, pc: pc,
                     a: {pc[15:0], 16'h0093},
                     b: {pc[15:0], 16'h0113},
                     dq: dq, fl: fl, exp: exp});
  endfunction

  initial begin
    logic [31:0] p;
    n_chk  = 0;
    n_fail = 0;

    vecs.push_back('{v: 1'b1, pc: 32'h100, a: 32'h00500093,
                     b: 32'h00A00113, dq: 2'd0, fl: 1'b0, exp: 2});
    add(1, 32'h108, 0, 0, 4);
    add(1, 32'h110, 0, 0, 6);
    add(1, 32'h118, 0, 0, 8);
    add(1, 32'h120, 0, 0, 8);
    for (int i = 7; i >= 0; i--) add(0, 0, 1, 0, i);

    p = 32'h400;
    for (int i = 1; i <= 3; i++) begin
      add(1, p, 0, 0, 2 * i);
      p += 8;
    end
    for (int i = 0; i < 10; i++) begin
      add(1, p, 2, 0, 6);
      p += 8;
    end
    add(0, 0, 1, 0, 5);
    for (int i = 0; i < 6; i++) begin
      add(1, p, 2, 0, 5);
      p += 8;
    end
    add(0, 0, 3, 0, 3);
    add(0, 0, 3, 0, 1);
    add(0, 0, 3, 0, 0);
    add(0, 0, 3, 0, 0);
    add(1, p, 0, 0, 2);
    add(0, 0, 1, 0, 1);
    add(0, 0, 2, 0, 0);

    add(1, 32'hFFFF_FFFE, 0, 0, 2);
    add(0, 0, 2, 0, 0);

    add(1, 32'h500, 0, 0, 2);
    add(1, 32'h508, 0, 0, 4);
    add(1, 32'h510, 0, 0, 6);
    add(0, 0, 1, 0, 5);
    add(1, 32'h300, 0, 1, 0);
    add(1, 32'h200, 0, 0, 2);
    add(0, 0, 0, 0, 2);
    add(0, 0, 2, 0, 0);

    add(1, 32'h600, 0, 0, 2);
    add(1, 32'h608, 0, 0, 4);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    check_sb();
    @(negedge clk);
    rst_n = 1'b1;
    check_sb();

    foreach (vecs[k]) begin
      drive(vecs[k].v, vecs[k].pc, vecs[k].a, vecs[k].b,
            vecs[k].dq, vecs[k].fl);
      @(negedge clk);
      check_sb();
      chk($sformatf("vec%0d_count", k),
          64'(bus.o_count), 64'(vecs[k].exp));
    end

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bus.o_count), 64'd0);
    chk("arst_validA", 64'(bus.o_validA), 64'd0);
    chk("arst_validB", 64'(bus.o_validB), 64'd0);
    chk("arst_ready", 64'(bus.o_ready), 64'd1);
    chk("arst_pcA", 64'(bus.o_pcA), 64'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 32'h700, 32'h11, 32'h22, 0, 0);
    @(negedge clk);
    check_sb();
    chk("post_rst_count", 64'(bus.o_count), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
